spike_readout_encoder: RTL and testbench

SPIKE_READOUT_ENCODER -- requirements
Module: spike_readout_encoder

---
 rtl/spike_readout_encoder_if.sv | 41 ++++
 rtl/spike_readout_encoder.sv | 187 ++++++++++++++++++
 tb/tb_spike_readout_encoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_readout_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_readout_encoder_if
// Description : Bundle of the spike-readout encoder's data-path signals.
//               The master side (SNN core / host) drives the tick strobe,
//               the spike vector, the FIFO pop and the counter clear. The
//               slave side (encoder) returns the FIFO head, its occupancy,
//               the busy flag and the saturating diagnostic counters.
//   master : enable, tick, spike_vector, pop, clear_counters  (outputs)
//            rd_data, rd_valid, fifo_count, busy,
//            overflow_count, tick_drop_count                  (inputs)
//   slave  : the same signals with the directions reversed
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_readout_encoder_if #(
   parameter int NUM_NEURONS = 1024,
   parameter int FIFO_DEPTH  = 256
);
   logic                          enable;
   logic                          tick;
   logic [NUM_NEURONS-1:0]        spike_vector;
   logic                          pop;
   logic                          clear_counters;
   logic [31:0]                   rd_data;
   logic                          rd_valid;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          busy;
   logic [15:0]                   overflow_count;
   logic [15:0]                   tick_drop_count;

   modport master (
      output enable, tick, spike_vector, pop, clear_counters,
      input  rd_data, rd_valid, fifo_count, busy, overflow_count, tick_drop_count
   );

   modport slave (
      input  enable, tick, spike_vector, pop, clear_counters,
      output rd_data, rd_valid, fifo_count, busy, overflow_count, tick_drop_count
   );
endinterface
`default_nettype wire

// File: rtl/spike_readout_encoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_readout_encoder
// Description : Converts a per-timestep spike vector into a stream of
//               address-event words {timestamp[15:0], neuron_id[15:0]}.
//               An accepted tick snapshots the vector; the scanner then walks
//               it 32 bits at a time, emitting one event per cycle for the
//               lowest set bit of the current word, and moves to the next
//               word when the current one is exhausted. Events go into a
//               show-ahead FIFO read by the host.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - spike_readout_encoder_if.slave (tick/vector in,
//                       FIFO read port, status and diagnostic counters out)
// Parameters  : NUM_NEURONS - multiple of 32, at most 65536
//               FIFO_DEPTH  - power of two, at least 2
// Revision    : 1.0 - initial release
// ============================================================================
module spike_readout_encoder #(
   parameter int NUM_NEURONS = 1024,
   parameter int FIFO_DEPTH  = 256
) (
   input  wire                    clk,
   input  wire                    rst_n,
   spike_readout_encoder_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int                  c_WORDS    = NUM_NEURONS / 32;
   localparam int                  c_WIDX_W   = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
   localparam int                  c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [c_WIDX_W-1:0] c_LAST_IDX = c_WIDX_W'(c_WORDS - 1);
   localparam logic [c_AW:0]       c_FULL     = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [15:0]         c_SAT      = 16'hFFFF;

   // Scanner state
   state_t                         r_state;
   logic                           r_busy;
   logic [c_WORDS-1:0][31:0]       r_snap;
   logic [c_WIDX_W-1:0]            r_word_idx;
   logic [15:0]                    r_ts_count;
   logic [15:0]                    r_ts_latch;
   logic [15:0]                    r_ovf_count;
   logic [15:0]                    r_drop_count;

   // Event FIFO
   logic [31:0]                    r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]                r_wr_ptr;
   logic [c_AW-1:0]                r_rd_ptr;
   logic [c_AW:0]                  r_count;

   logic [31:0]                    w_word;
   logic [4:0]                     w_bit;
   logic [15:0]                    w_id;
   logic [31:0]                    w_event;
   logic                           w_emit;
   logic                           w_accept;
   logic                           w_tick_drop;
   logic                           w_full;
   logic                           w_pop_ok;
   logic                           w_push_ok;
   logic                           w_overflow;

   assign w_word = r_snap[r_word_idx];

   // Lowest set bit of the current word wins, giving ascending id order.
   always_comb begin
      w_bit = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (w_word[i]) begin
            w_bit = 5'(i);
         end
      end
   end

   // word_idx*32 + bit is simply the concatenation, zero-extended to 16 bits.
   assign w_id        = 16'({r_word_idx, w_bit});
   assign w_event     = {r_ts_latch, w_id};
   assign w_emit      = (r_state == SCAN) && (w_word != 32'd0);
   assign w_accept    = bus.tick && bus.enable && (r_state == IDLE);
   // Drops are judged on the registered state, so a tick in the final SCAN
   // cycle is still a drop even though the FSM is about to return to IDLE.
   assign w_tick_drop = bus.tick && (r_state == SCAN);

   // A pop on a full FIFO frees the slot the same-cycle push lands in, so the
   // push is only refused when full with no accepted pop.
   assign w_full      = (r_count == c_FULL);
   assign w_pop_ok    = bus.pop && (r_count != '0);
   assign w_push_ok   = w_emit && (!w_full || w_pop_ok);
   assign w_overflow  = w_emit && w_full && !w_pop_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_snap       <= '0;
         r_word_idx   <= '0;
         r_ts_count   <= 16'd0;
         r_ts_latch   <= 16'd0;
         r_ovf_count  <= 16'd0;
         r_drop_count <= 16'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_snap     <= bus.spike_vector;
                  r_ts_latch <= r_ts_count;
                  r_word_idx <= '0;
                  r_state    <= SCAN;
                  r_busy     <= 1'b1;
               end
            end
            SCAN: begin
               if (w_word != 32'd0) begin
                  // x & (x-1) strips the lowest set bit just emitted.
                  r_snap[r_word_idx] <= w_word & (w_word - 32'd1);
               end else if (r_word_idx == c_LAST_IDX) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_word_idx <= r_word_idx + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         if (bus.clear_counters) begin
            r_ts_count   <= 16'd0;
            r_ovf_count  <= 16'd0;
            r_drop_count <= 16'd0;
         end else begin
            if (w_accept) begin
               r_ts_count <= r_ts_count + 16'd1;
            end
            if (w_overflow && (r_ovf_count != c_SAT)) begin
               r_ovf_count <= r_ovf_count + 16'd1;
            end
            if (w_tick_drop && (r_drop_count != c_SAT)) begin
               r_drop_count <= r_drop_count + 16'd1;
            end
         end
      end
   end

   // Storage needs no reset: emptiness is defined by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= w_event;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.rd_valid        = (r_count != '0);
   assign bus.rd_data         = (r_count != '0) ? r_mem[r_rd_ptr] : 32'd0;
   assign bus.fifo_count      = r_count;
   assign bus.busy            = r_busy;
   assign bus.overflow_count  = r_ovf_count;
   assign bus.tick_drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_spike_readout_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_readout_encoder
// Description : Self-checking bench for spike_readout_encoder. Stimulus
//               pushes hand-computed event words into an expected queue; a
//               monitor on the falling edge pops and compares whenever the
//               host pops a valid head. Status and counters are checked
//               directly at fixed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_readout_encoder;

   localparam int c_N     = 1024;
   localparam int c_DEPTH = 256;

   logic clk;
   logic rst_n;

   spike_readout_encoder_if #(.NUM_NEURONS(c_N), .FIFO_DEPTH(c_DEPTH)) bus ();

   spike_readout_encoder #(.NUM_NEURONS(c_N), .FIFO_DEPTH(c_DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: compare the head on every accepted pop.
   always @(negedge clk) begin
      if (rst_n && bus.pop && bus.rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected actual=0x%08h expected=none", bus.rd_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.rd_data !== e) begin
               failures++;
               $display("FAIL event actual=0x%08h expected=0x%08h", bus.rd_data, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.tick = 1'b0;
      bus.pop  = 1'b0;
      bus.clear_counters = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic send_tick(input logic [c_N-1:0] vec, input logic en);
      bus.tick         = 1'b1;
      bus.enable       = en;
      bus.spike_vector = vec;
      step();
      bus.tick         = 1'b0;
      bus.enable       = 1'b1;
   endtask

   // Counts the cycles busy stays high from the current sample point.
   task automatic run_scan(output int cyc);
      cyc = 0;
      while (bus.busy && cyc < 5000) begin
         cyc++;
         step();
      end
      if (bus.busy) begin
         checks++;
         failures++;
         $display("FAIL scan_timeout actual=busy expected=idle");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.pop = 1'b1;
      while (bus.rd_valid && n < 2000) begin
         n++;
         step();
      end
      bus.pop = 1'b0;
      if (bus.rd_valid) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=valid expected=empty");
      end
   endtask

   function automatic logic [31:0] ev(input logic [15:0] ts, input logic [15:0] id);
      return {ts, id};
   endfunction

   initial begin
      logic [c_N-1:0] vec;
      int             cyc;
      logic           full_held;

      rst_n              = 1'b0;
      bus.enable         = 1'b1;
      bus.tick           = 1'b0;
      bus.spike_vector   = '0;
      bus.pop            = 1'b0;
      bus.clear_counters = 1'b0;
      step();
      step();
      check("rst_busy",       bus.busy, 0);
      check("rst_rd_valid",   bus.rd_valid, 0);
      check("rst_fifo_count", bus.fifo_count, 0);
      check("rst_rd_data",    bus.rd_data, 0);
      check("rst_overflow",   bus.overflow_count, 0);
      check("rst_drops",      bus.tick_drop_count, 0);
      rst_n = 1'b1;
      step();

      // Bits 0, 5, 1023: three events, 32 words + 3 spikes of busy.
      vec = '0; vec[0] = 1'b1; vec[5] = 1'b1; vec[1023] = 1'b1;
      exp_q.push_back(ev(0, 0));
      exp_q.push_back(ev(0, 5));
      exp_q.push_back(ev(0, 1023));
      send_tick(vec, 1'b1);
      run_scan(cyc);
      check("busy_3spk", cyc, 35);
      check("count_3spk", bus.fifo_count, 3);
      check("head_3spk", bus.rd_data, 32'h0000_0000);
      drain();
      check("sb_empty_3spk", exp_q.size(), 0);

      // Pop held high from an empty FIFO: empty-pop ignored, push+pop balanced.
      do_reset();
      vec = '0; vec[0] = 1'b1; vec[2] = 1'b1;
      exp_q.push_back(ev(0, 0));
      exp_q.push_back(ev(0, 2));
      bus.pop = 1'b1;
      send_tick(vec, 1'b1);
      run_scan(cyc);
      bus.pop = 1'b0;
      check("busy_pp_empty", cyc, 34);
      check("count_pp_empty", bus.fifo_count, 0);
      check("sb_empty_pp", exp_q.size(), 0);

      // Two empty ticks then bit 33 at timestamp 2.
      do_reset();
      send_tick('0, 1'b1);
      run_scan(cyc);
      check("busy_empty1", cyc, 32);
      check("count_empty1", bus.fifo_count, 0);
      send_tick('0, 1'b1);
      run_scan(cyc);
      check("busy_empty2", cyc, 32);
      vec = '0; vec[33] = 1'b1;
      exp_q.push_back(32'h0002_0021);
      send_tick(vec, 1'b1);
      run_scan(cyc);
      check("busy_bit33", cyc, 33);
      drain();
      check("sb_empty_bit33", exp_q.size(), 0);

      // Disabled tick ignored; then tick, second tick 3 cycles later dropped.
      do_reset();
      vec = '0; vec[7] = 1'b1;
      send_tick(vec, 1'b0);
      check("dis_busy", bus.busy, 0);
      check("dis_drops", bus.tick_drop_count, 0);
      exp_q.push_back(ev(0, 7));
      send_tick(vec, 1'b1);
      step();
      step();
      send_tick('1, 1'b1);
      run_scan(cyc);
      check("drop_one", bus.tick_drop_count, 1);
      check("count_drop", bus.fifo_count, 1);
      drain();
      check("sb_empty_drop", exp_q.size(), 0);

      // Clear beats a same-cycle drop increment; ts_count also zeroed.
      exp_q.push_back(ev(1, 7));
      send_tick(vec, 1'b1);
      bus.tick = 1'b1;
      bus.clear_counters = 1'b1;
      step();
      bus.tick = 1'b0;
      bus.clear_counters = 1'b0;
      run_scan(cyc);
      check("clear_prio_drops", bus.tick_drop_count, 0);
      drain();
      exp_q.push_back(ev(0, 7));
      send_tick(vec, 1'b1);
      run_scan(cyc);
      drain();
      check("sb_empty_clear", exp_q.size(), 0);

      // Tick during the final SCAN cycle is a drop, not an accept.
      do_reset();
      send_tick('0, 1'b1);
      repeat (31) step();
      vec = '0; vec[1] = 1'b1;
      send_tick(vec, 1'b1);
      check("edge_tick_busy", bus.busy, 0);
      check("edge_tick_drops", bus.tick_drop_count, 1);
      step();
      check("edge_tick_count", bus.fifo_count, 0);

      // All bits set, no pop: 256 stored, 768 dropped.
      do_reset();
      for (int i = 0; i < 256; i++) exp_q.push_back(ev(0, 16'(i)));
      send_tick('1, 1'b1);
      run_scan(cyc);
      check("busy_full", cyc, 1056);
      check("count_full", bus.fifo_count, 256);
      check("overflow_full", bus.overflow_count, 768);
      check("head_full", bus.rd_data, 32'h0000_0000);

      // Full FIFO, all bits again, pop high through the scan: no overflow.
      bus.clear_counters = 1'b1;
      step();
      bus.clear_counters = 1'b0;
      check("overflow_cleared", bus.overflow_count, 0);
      for (int i = 0; i < 1024; i++) exp_q.push_back(ev(0, 16'(i)));
      send_tick('1, 1'b1);
      bus.pop   = 1'b1;
      cyc       = 0;
      full_held = 1'b1;
      while (bus.busy && cyc < 5000) begin
         if (cyc < 32 && bus.fifo_count != 256) full_held = 1'b0;
         cyc++;
         step();
      end
      bus.pop = 1'b0;
      check("pp_full_hold", full_held, 1);
      check("pp_full_busy", cyc, 1056);
      check("pp_full_overflow", bus.overflow_count, 0);
      check("pp_full_count", bus.fifo_count, 224);
      drain();
      check("sb_empty_full", exp_q.size(), 0);

      // Reset mid-scan with 10 events buffered.
      do_reset();
      vec = '0;
      for (int i = 0; i < 10; i++) vec[i] = 1'b1;
      vec[500] = 1'b1;
      send_tick(vec, 1'b1);
      repeat (10) step();
      check("mid_count10", bus.fifo_count, 10);
      send_tick('0, 1'b1);
      check("mid_drops", bus.tick_drop_count, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_valid", bus.rd_valid, 0);
      check("mid_rst_count", bus.fifo_count, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_drops", bus.tick_drop_count, 0);
      check("mid_rst_ovf", bus.overflow_count, 0);
      step();
      check("post_rst_valid", bus.rd_valid, 0);
      check("post_rst_busy", bus.busy, 0);
      vec = '0; vec[3] = 1'b1;
      exp_q.push_back(ev(0, 3));
      send_tick(vec, 1'b1);
      run_scan(cyc);
      drain();
      check("sb_empty_final", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
